// File: rtl/palindrome_gen.sv
// palindrome_gen: builds a DATA_WIDTH-bit binary palindrome from a half-width seed.
// The seed fills the upper half; the lower half is mirrored in one bit per clock.
//
// Ports:
//   clk        in   rising-edge clock
//   resetn     in   asynchronous active-low reset
//   din        in   seed, becomes dout[DATA_WIDTH-1 -: HALF]
//   din_valid  in   seed offered
//   din_ready  out  block is idle and can take a seed
//   dout       out  work register; complete only while dout_valid=1
//   dout_valid out  dout holds a finished palindrome
//   dout_ready in   consumer takes dout
//   busy       out  building or holding a result
module palindrome_gen #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [(DATA_WIDTH+1)/2-1:0]     din,
    input  logic                            din_valid,
    output logic                            din_ready,
    output logic [DATA_WIDTH-1:0]           dout,
    output logic                            dout_valid,
    input  logic                            dout_ready,
    output logic                            busy
);

    localparam int HALF = (DATA_WIDTH + 1) / 2;
    localparam int NMIR = DATA_WIDTH / 2;
    localparam int CW   = (NMIR > 0) ? $clog2(NMIR + 1) : 1;
    localparam int LAST = (NMIR > 0) ? NMIR - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUILD,
        S_DONE
    } state_t;

    // A 1-bit word has nothing to mirror and is finished on load.
    localparam state_t S_LOADED = (NMIR > 0) ? S_BUILD : S_DONE;

    state_t                r_state;
    state_t                w_next_state;
    logic [DATA_WIDTH-1:0] r_work;
    logic [DATA_WIDTH-1:0] w_work_nxt;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_nxt;
    logic                  w_last;

    assign w_last = (r_cnt == CW'(LAST));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:  if (din_valid)  w_next_state = S_LOADED;
            S_BUILD: if (w_last)     w_next_state = S_DONE;
            S_DONE:  if (dout_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_work_nxt = r_work;
        w_cnt_nxt  = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (din_valid) begin
                    w_work_nxt = '0;
                    w_work_nxt[DATA_WIDTH-1 -: HALF] = din;
                    w_cnt_nxt  = '0;
                end
            end
            S_BUILD: begin
                // Constant bit indices keep the mirror select lint-clean for any width.
                for (int i = 0; i < NMIR; i++) begin
                    if (r_cnt == CW'(i)) begin
                        w_work_nxt[i] = r_work[DATA_WIDTH-1-i];
                    end
                end
                w_cnt_nxt = r_cnt + CW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_work <= '0;
            r_cnt  <= '0;
        end else begin
            r_work <= w_work_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign dout       = r_work;
    assign din_ready  = (r_state == S_IDLE);
    assign dout_valid = (r_state == S_DONE);
    assign busy       = (r_state != S_IDLE);

endmodule
